// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types, coin values and helpers for the vending controller
//
// Purpose : FSM state encoding, coin denominations, size limits and two small
//           helpers (price lookup from the packed price vector, one-hot test).
// Ports   : none (package).
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_e;

  localparam int NICKEL  = 5;
  localparam int DIME    = 10;
  localparam int QUARTER = 25;

  // Upper bounds used to size the helper arguments; the top checks its
  // parameters against these at elaboration.
  localparam int MAX_PROD = 8;
  localparam int MAX_CW   = 16;

  // Extract the price of product idx from a zero-extended packed price vector.
  function automatic logic [MAX_CW-1:0] price_of(input logic [MAX_PROD*MAX_CW-1:0] prices,
                                                 input int cw, input int idx);
    logic [MAX_PROD*MAX_CW-1:0] shifted;
    logic [MAX_CW-1:0]          mask;
    shifted = prices >> (idx * cw);
    mask    = (MAX_CW'(1) << cw) - MAX_CW'(1);
    return shifted[MAX_CW-1:0] & mask;
  endfunction

  function automatic logic is_onehot(input logic [MAX_PROD-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/vending_if.sv
// rtl/vending_if.sv - coin/selection inputs and dispenser/display outputs of the controller
//
// Purpose : bundles every non-clock signal of vending_ctrl.
// Ports   : master = input debouncer / display side (drives coins, sel, cancel,
//           restock; observes credit, vend, change_*, coin_reject, deny,
//           sold_out, busy); slave = the controller (the reverse).
interface vending_if #(
  parameter int NUM_PROD = 4,
  parameter int CW       = 6
);
  logic                coin_n;
  logic                coin_d;
  logic                coin_q;
  logic [NUM_PROD-1:0] sel;
  logic                cancel;
  logic                restock;
  logic [CW-1:0]       credit;
  logic [NUM_PROD-1:0] vend;
  logic                change_n;
  logic                change_d;
  logic                change_q;
  logic                coin_reject;
  logic                deny;
  logic [NUM_PROD-1:0] sold_out;
  logic                busy;

  modport master (
    output coin_n, coin_d, coin_q, sel, cancel, restock,
    input  credit, vend, change_n, change_d, change_q, coin_reject, deny, sold_out, busy
  );

  modport slave (
    input  coin_n, coin_d, coin_q, sel, cancel, restock,
    output credit, vend, change_n, change_d, change_q, coin_reject, deny, sold_out, busy
  );
endinterface

// File: rtl/vending_stock.sv
// rtl/vending_stock.sv - per-product stock counters with restock and sold-out flags
//
// Purpose : one saturating down-counter per product.
// Ports   : clk, reset (sync, active-high); dec_en_i/dec_idx_i decrement one
//           counter; restock_i reloads every counter (wins over a decrement);
//           sold_out_o[i] is high while counter i is zero (combinational).
module vending_stock #(
  parameter int NUM_PROD   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10,
  parameter int IDX_W      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_en_i,
  input  logic [IDX_W-1:0]    dec_idx_i,
  input  logic                restock_i,
  output logic [NUM_PROD-1:0] sold_out_o
);

  logic [STOCK_W-1:0] stock_q [NUM_PROD];
  logic [STOCK_W-1:0] stock_d [NUM_PROD];

  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      stock_d[i] = stock_q[i];
      if (restock_i) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end else if (dec_en_i && (dec_idx_i == IDX_W'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROD; i++) begin
      if (reset) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      sold_out_o[i] = (stock_q[i] == '0);
    end
  end

endmodule

// File: rtl/vending_ctrl.sv
// rtl/vending_ctrl.sv - credit accumulation, vend decision and greedy change return
//
// Purpose : IDLE accepts coins / selection / cancel (priority cancel > sel > coin),
//           VEND lasts one cycle, CHANGE pays out credit one coin per cycle,
//           largest coin first.
// Ports   : clk, reset (sync, active-high); vif (vending_if.slave) carries the
//           coin/sel/cancel/restock inputs and the registered credit and pulse
//           outputs, plus combinational sold_out and busy.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int                     NUM_PROD    = 4,
  parameter int                     CW          = 6,
  parameter logic [NUM_PROD*CW-1:0] PRICES      = {6'd30, 6'd25, 6'd20, 6'd15},
  parameter int                     MAX_CREDIT  = 35,
  parameter int                     STOCK_W     = 4,
  parameter int                     STOCK_INIT  = 10,
  parameter bit                     AUTO_CHANGE = 1'b1
) (
  input logic     clk,
  input logic     reset,
  vending_if.slave vif
);

  localparam int IDX_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
  localparam int PW    = MAX_PROD * MAX_CW;
  localparam logic [PW-1:0] PRICES_EXT = PW'(PRICES);

  if (NUM_PROD < 1 || NUM_PROD > MAX_PROD || CW > MAX_CW) begin : g_bad_size
    $error("vending_ctrl: NUM_PROD or CW out of range");
  end
  if ((MAX_CREDIT % 5) != 0 || MAX_CREDIT >= (1 << CW)) begin : g_bad_max
    $error("vending_ctrl: MAX_CREDIT must be a multiple of 5 below 2**CW");
  end
  for (genvar gp = 0; gp < NUM_PROD; gp++) begin : g_price_chk
    if ((int'(PRICES[gp*CW +: CW]) % 5) != 0 || int'(PRICES[gp*CW +: CW]) > MAX_CREDIT) begin : g_bad
      $error("vending_ctrl: price must be a multiple of 5 and <= MAX_CREDIT");
    end
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic [NUM_PROD-1:0] vend_q, vend_d;
  logic                change_n_q, change_n_d;
  logic                change_d_q, change_d_d;
  logic                change_q_q, change_q_d;
  logic                reject_q, reject_d;
  logic                deny_q, deny_d;

  logic                coin_any, coin_multi;
  logic [CW:0]         coin_val, credit_sum;
  logic                sel_any, sel_in_stock;
  logic [CW-1:0]       sel_price;
  logic [IDX_W-1:0]    sel_idx;
  logic [MAX_CW-1:0]   price_raw;
  logic                dec_en;
  logic [NUM_PROD-1:0] sold_out;

  assign coin_any   = vif.coin_n | vif.coin_d | vif.coin_q;
  assign coin_multi = (vif.coin_n & vif.coin_d) | (vif.coin_n & vif.coin_q) | (vif.coin_d & vif.coin_q);
  // Highest coin wins when several arrive together.
  assign coin_val   = vif.coin_q ? (CW+1)'(QUARTER) :
                      vif.coin_d ? (CW+1)'(DIME)    :
                      vif.coin_n ? (CW+1)'(NICKEL)  : '0;
  // One extra bit so credit + coin can never wrap before the ceiling compare.
  assign credit_sum = {1'b0, credit_q} + coin_val;

  assign sel_any      = |vif.sel;
  // Exact for a one-hot select, which is the only case it is used in.
  assign sel_in_stock = |(vif.sel & ~sold_out);

  always_comb begin
    price_raw = '0;
    sel_price = '0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (vif.sel[i]) begin
        price_raw = price_of(PRICES_EXT, CW, i);
        sel_price = price_raw[CW-1:0];
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    vend_d     = '0;
    change_n_d = 1'b0;
    change_d_d = 1'b0;
    change_q_d = 1'b0;
    reject_d   = 1'b0;
    deny_d     = 1'b0;
    dec_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (vif.cancel) begin
          reject_d = coin_any;
          if (credit_q != '0) begin
            state_d = CHANGE;
          end
        end else if (sel_any) begin
          reject_d = coin_any;
          if (!is_onehot(MAX_PROD'(vif.sel))) begin
            deny_d = 1'b1;
          end else if ((credit_q >= sel_price) && sel_in_stock) begin
            vend_d   = vif.sel;
            credit_d = credit_q - sel_price;
            dec_en   = 1'b1;
            state_d  = VEND;
          end else begin
            deny_d = 1'b1;
          end
        end else if (coin_any) begin
          if (credit_sum <= (CW+1)'(MAX_CREDIT)) begin
            credit_d = credit_sum[CW-1:0];
            reject_d = coin_multi;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      VEND: begin
        reject_d = coin_any;
        if (AUTO_CHANGE && (credit_q != '0)) begin
          state_d = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end

      CHANGE: begin
        reject_d = coin_any;
        if (credit_q >= CW'(QUARTER)) begin
          change_q_d = 1'b1;
          credit_d   = credit_q - CW'(QUARTER);
        end else if (credit_q >= CW'(DIME)) begin
          change_d_d = 1'b1;
          credit_d   = credit_q - CW'(DIME);
        end else if (credit_q >= CW'(NICKEL)) begin
          change_n_d = 1'b1;
          credit_d   = credit_q - CW'(NICKEL);
        end else begin
          // Sub-nickel residue cannot be paid out; credit is always a multiple of 5.
          credit_d = '0;
        end
        if (credit_d == '0) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      vend_q     <= '0;
      change_n_q <= 1'b0;
      change_d_q <= 1'b0;
      change_q_q <= 1'b0;
      reject_q   <= 1'b0;
      deny_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      vend_q     <= vend_d;
      change_n_q <= change_n_d;
      change_d_q <= change_d_d;
      change_q_q <= change_q_d;
      reject_q   <= reject_d;
      deny_q     <= deny_d;
    end
  end

  vending_stock #(
    .NUM_PROD  (NUM_PROD),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT),
    .IDX_W     (IDX_W)
  ) u_stock (
    .clk       (clk),
    .reset     (reset),
    .dec_en_i  (dec_en),
    .dec_idx_i (sel_idx),
    .restock_i (vif.restock),
    .sold_out_o(sold_out)
  );

  assign vif.credit      = credit_q;
  assign vif.vend        = vend_q;
  assign vif.change_n    = change_n_q;
  assign vif.change_d    = change_d_q;
  assign vif.change_q    = change_q_q;
  assign vif.coin_reject = reject_q;
  assign vif.deny        = deny_q;
  assign vif.sold_out    = sold_out;
  assign vif.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vending_ctrl.sv
// tb/tb_vending_ctrl.sv - randomized and directed checks of vending_ctrl against a transaction model
module tb_vending_ctrl;

  localparam int SI   = 10;
  localparam int MAXC = 35;

  logic clk = 1'b0;
  logic reset0, reset1;
  always #5 clk = ~clk;

  vending_if #(.NUM_PROD(4), .CW(6)) bus0 ();
  vending_if #(.NUM_PROD(2), .CW(6)) bus1 ();

  vending_ctrl #(
    .NUM_PROD(4), .CW(6), .PRICES({6'd30, 6'd25, 6'd20, 6'd15}), .MAX_CREDIT(35),
    .STOCK_W(4), .STOCK_INIT(10), .AUTO_CHANGE(1'b1)
  ) dut0 (.clk(clk), .reset(reset0), .vif(bus0));

  vending_ctrl #(
    .NUM_PROD(2), .CW(6), .PRICES({6'd20, 6'd15}), .MAX_CREDIT(35),
    .STOCK_W(4), .STOCK_INIT(10), .AUTO_CHANGE(1'b0)
  ) dut1 (.clk(clk), .reset(reset1), .vif(bus1));

  // Transaction-level model: credit in cents, stock per product.
  int m_credit [2];
  int m_stock  [2][4];
  int m_price  [2][4] = '{'{15, 20, 25, 30}, '{15, 20, 0, 0}};
  int m_np     [2]    = '{4, 2};
  bit m_auto   [2]    = '{1'b1, 1'b0};

  int checks   = 0;
  int failures = 0;

  logic [5:0] o_credit;
  logic [3:0] o_vend, o_sold;
  logic       o_cn, o_cd, o_cq, o_rej, o_deny, o_busy;

  task automatic drive(int u, bit n, bit d, bit q, logic [3:0] s, bit c, bit r);
    if (u == 0) begin
      bus0.coin_n = n; bus0.coin_d = d; bus0.coin_q = q;
      bus0.sel = s; bus0.cancel = c; bus0.restock = r;
    end else begin
      bus1.coin_n = n; bus1.coin_d = d; bus1.coin_q = q;
      bus1.sel = s[1:0]; bus1.cancel = c; bus1.restock = r;
    end
  endtask

  task automatic idle_inputs(int u);
    drive(u, 0, 0, 0, 4'b0000, 0, 0);
  endtask

  task automatic sample(int u);
    if (u == 0) begin
      o_credit = bus0.credit; o_vend = bus0.vend; o_sold = bus0.sold_out;
      o_cn = bus0.change_n; o_cd = bus0.change_d; o_cq = bus0.change_q;
      o_rej = bus0.coin_reject; o_deny = bus0.deny; o_busy = bus0.busy;
    end else begin
      o_credit = bus1.credit; o_vend = {2'b00, bus1.vend}; o_sold = {2'b00, bus1.sold_out};
      o_cn = bus1.change_n; o_cd = bus1.change_d; o_cq = bus1.change_q;
      o_rej = bus1.coin_reject; o_deny = bus1.deny; o_busy = bus1.busy;
    end
  endtask

  task automatic set_reset(int u, bit v);
    if (u == 0) reset0 = v; else reset1 = v;
  endtask

  task automatic model_reset(int u);
    m_credit[u] = 0;
    for (int i = 0; i < 4; i++) m_stock[u][i] = SI;
  endtask

  function automatic logic [3:0] model_sold(int u);
    logic [3:0] v = '0;
    for (int i = 0; i < m_np[u]; i++) v[i] = (m_stock[u][i] == 0);
    return v;
  endfunction

  // One IDLE transaction, followed by the change payout it causes, if any.
  task automatic do_txn(int u, bit n, bit d, bit q, logic [3:0] s, bit c, bit r);
    int c0, ones, idx, val, e_mid, e_chg, nq, nd, nn;
    bit e_deny, e_rej, e_busy, vended, bad;
    logic [3:0] e_vend, e_sold;
    int seq [$];
    int exp_seq [$];
    c0 = m_credit[u]; ones = $countones(s);
    e_deny = 0; e_rej = 0; e_busy = 0; vended = 0; e_vend = '0; e_chg = 0; idx = 0;
    if (c) begin
      e_rej = n | d | q;
      e_mid = c0;
      if (c0 > 0) begin e_chg = c0; e_busy = 1; m_credit[u] = 0; end
    end else if (ones > 0) begin
      e_rej = n | d | q;
      if (ones != 1) e_deny = 1;
      else begin
        for (int i = 0; i < 4; i++) if (s[i]) idx = i;
        if (c0 >= m_price[u][idx] && m_stock[u][idx] > 0) begin
          vended = 1; e_vend = s; e_busy = 1;
          m_credit[u] = c0 - m_price[u][idx];
          m_stock[u][idx] = m_stock[u][idx] - 1;
          if (m_auto[u] && m_credit[u] > 0) begin e_chg = m_credit[u]; m_credit[u] = 0; end
          e_mid = c0 - m_price[u][idx];
        end else e_deny = 1;
      end
    end else if (n | d | q) begin
      val = q ? 25 : (d ? 10 : 5);
      if (c0 + val <= MAXC) begin
        m_credit[u] = c0 + val;
        e_rej = (int'(n) + int'(d) + int'(q)) > 1;
      end else e_rej = 1;
    end
    if (r) for (int i = 0; i < 4; i++) m_stock[u][i] = SI;
    if (!c && !vended) e_mid = m_credit[u];
    e_sold = model_sold(u);

    drive(u, n, d, q, s, c, r);
    @(negedge clk);
    sample(u);
    idle_inputs(u);
    checks++;
    if (o_vend !== e_vend || o_deny !== e_deny || o_rej !== e_rej || o_credit !== 6'(e_mid) ||
        o_busy !== e_busy || o_sold !== e_sold || {o_cn, o_cd, o_cq} !== 3'b000) begin
      failures++;
      $display("FAIL txn u%0d n%0b d%0b q%0b sel=%b c%0b r%0b: vend=%b deny=%b rej=%b credit=%0d busy=%b sold=%b chg=%b, required vend=%b deny=%b rej=%b credit=%0d busy=%b sold=%b chg=000",
               u, n, d, q, s, c, r, o_vend, o_deny, o_rej, o_credit, o_busy, o_sold, {o_cn, o_cd, o_cq},
               e_vend, e_deny, e_rej, e_mid, e_busy, e_sold);
    end

    if (vended && e_chg == 0) begin
      @(negedge clk);
      sample(u);
      checks++;
      if (o_busy !== 1'b0 || o_credit !== 6'(m_credit[u]) || {o_cn, o_cd, o_cq} !== 3'b000) begin
        failures++;
        $display("FAIL vend_end u%0d: busy=%b credit=%0d chg=%b, required busy=0 credit=%0d chg=000",
                 u, o_busy, o_credit, {o_cn, o_cd, o_cq}, m_credit[u]);
      end
    end

    if (e_chg > 0) begin
      if (vended) begin
        @(negedge clk);
        sample(u);
        checks++;
        if (o_busy !== 1'b1 || {o_cn, o_cd, o_cq} !== 3'b000) begin
          failures++;
          $display("FAIL vend_to_change u%0d: busy=%b chg=%b, required busy=1 chg=000", u, o_busy, {o_cn, o_cd, o_cq});
        end
      end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        sample(u);
        if (int'(o_cn) + int'(o_cd) + int'(o_cq) != 1 || o_vend !== 4'b0 || o_deny || o_rej) bad = 1;
        if (o_cq) seq.push_back(25); else if (o_cd) seq.push_back(10); else if (o_cn) seq.push_back(5);
        if (!o_busy) break;
      end
      nq = e_chg / 25; nd = (e_chg % 25) / 10; nn = ((e_chg % 25) % 10) / 5;
      for (int i = 0; i < nq; i++) exp_seq.push_back(25);
      for (int i = 0; i < nd; i++) exp_seq.push_back(10);
      for (int i = 0; i < nn; i++) exp_seq.push_back(5);
      if (seq.size() != exp_seq.size()) bad = 1;
      else for (int i = 0; i < seq.size(); i++) if (seq[i] != exp_seq[i]) bad = 1;
      checks++;
      if (bad || o_busy !== 1'b0 || o_credit !== 6'd0) begin
        failures++;
        $display("FAIL change_seq u%0d from %0d: got %0d coins busy=%b credit=%0d, required %0d coins (q%0d d%0d n%0d) busy=0 credit=0",
                 u, e_chg, seq.size(), o_busy, o_credit, exp_seq.size(), nq, nd, nn);
      end
    end
  endtask

  task automatic test_reset(int u);
    idle_inputs(u);
    set_reset(u, 1);
    repeat (2) @(negedge clk);
    sample(u);
    checks++;
    if (o_credit !== 6'd0 || o_busy !== 1'b0 || o_vend !== 4'b0 || o_sold !== 4'b0 ||
        {o_cn, o_cd, o_cq, o_rej, o_deny} !== 5'b0) begin
      failures++;
      $display("FAIL reset u%0d: credit=%0d busy=%b vend=%b sold=%b pulses=%b, required all zero",
               u, o_credit, o_busy, o_vend, o_sold, {o_cn, o_cd, o_cq, o_rej, o_deny});
    end
    set_reset(u, 0);
    model_reset(u);
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_txn(0, 0, 0, 1, 4'b0000, 0, 0);
    do_txn(0, 1, 0, 0, 4'b0000, 0, 0);
    do_txn(0, 0, 0, 0, 4'b0010, 0, 0);
  endtask

  task automatic test_overflow;
    repeat (3) do_txn(0, 0, 1, 0, 4'b0000, 0, 0);
    do_txn(0, 0, 0, 1, 4'b0000, 0, 0);
    do_txn(0, 0, 0, 0, 4'b0000, 1, 0);
  endtask

  task automatic test_deny;
    do_txn(0, 0, 1, 0, 4'b0000, 0, 0);
    do_txn(0, 0, 0, 0, 4'b0001, 0, 0);
    do_txn(0, 0, 0, 0, 4'b0011, 0, 0);
    do_txn(0, 0, 0, 0, 4'b0000, 1, 0);
  endtask

  task automatic test_sold_out;
    do_txn(0, 0, 0, 0, 4'b0000, 0, 1);
    repeat (SI) begin
      do_txn(0, 0, 1, 0, 4'b0000, 0, 0);
      do_txn(0, 1, 0, 0, 4'b0000, 0, 0);
      do_txn(0, 0, 0, 0, 4'b0001, 0, 0);
    end
    checks++;
    if (o_sold[0] !== 1'b1) begin
      failures++;
      $display("FAIL sold_out_set: sold_out[0]=%b, required 1", o_sold[0]);
    end
    do_txn(0, 0, 1, 0, 4'b0000, 0, 0);
    do_txn(0, 1, 0, 0, 4'b0000, 0, 0);
    do_txn(0, 0, 0, 0, 4'b0001, 0, 0);
    checks++;
    if (o_deny !== 1'b1 || o_credit !== 6'd15) begin
      failures++;
      $display("FAIL sold_out_deny: deny=%b credit=%0d, required deny=1 credit=15", o_deny, o_credit);
    end
    do_txn(0, 0, 0, 0, 4'b0000, 0, 1);
    checks++;
    if (o_sold[0] !== 1'b0) begin
      failures++;
      $display("FAIL restock_clear: sold_out[0]=%b, required 0", o_sold[0]);
    end
    do_txn(0, 0, 0, 0, 4'b0001, 0, 0);
  endtask

  task automatic test_busy_inject;
    do_txn(0, 0, 0, 1, 4'b0000, 0, 0);
    do_txn(0, 0, 1, 0, 4'b0000, 0, 0);
    drive(0, 0, 0, 0, 4'b0000, 1, 0);
    @(negedge clk);
    sample(0);
    drive(0, 1, 0, 0, 4'b0001, 1, 0);
    @(negedge clk);
    sample(0);
    idle_inputs(0);
    checks++;
    if (o_cq !== 1'b1 || o_rej !== 1'b1 || o_deny !== 1'b0 || o_vend !== 4'b0 || o_credit !== 6'd10 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL inject_first: cq=%b rej=%b deny=%b vend=%b credit=%0d busy=%b, required cq=1 rej=1 deny=0 vend=0 credit=10 busy=1",
               o_cq, o_rej, o_deny, o_vend, o_credit, o_busy);
    end
    @(negedge clk);
    sample(0);
    checks++;
    if (o_cd !== 1'b1 || o_rej !== 1'b0 || o_credit !== 6'd0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL inject_second: cd=%b rej=%b credit=%0d busy=%b, required cd=1 rej=0 credit=0 busy=0",
               o_cd, o_rej, o_credit, o_busy);
    end
    m_credit[0] = 0;
  endtask

  task automatic test_reset_mid_change;
    do_txn(0, 0, 0, 1, 4'b0000, 0, 0);
    do_txn(0, 0, 1, 0, 4'b0000, 0, 0);
    drive(0, 0, 0, 0, 4'b0000, 1, 0);
    @(negedge clk);
    idle_inputs(0);
    @(negedge clk);
    sample(0);
    checks++;
    if (o_cq !== 1'b1 || o_credit !== 6'd10) begin
      failures++;
      $display("FAIL pre_reset: cq=%b credit=%0d, required cq=1 credit=10", o_cq, o_credit);
    end
    reset0 = 1'b1;
    @(negedge clk);
    sample(0);
    checks++;
    if (o_credit !== 6'd0 || o_busy !== 1'b0 || {o_cn, o_cd, o_cq} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_change: credit=%0d busy=%b chg=%b, required credit=0 busy=0 chg=000",
               o_credit, o_busy, {o_cn, o_cd, o_cq});
    end
    reset0 = 1'b0;
    model_reset(0);
    @(negedge clk);
  endtask

  task automatic test_no_auto;
    do_txn(1, 0, 0, 1, 4'b0000, 0, 0);
    do_txn(1, 0, 1, 0, 4'b0000, 0, 0);
    do_txn(1, 0, 0, 0, 4'b0001, 0, 0);
    checks++;
    if (o_credit !== 6'd20 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL no_auto_keep: credit=%0d busy=%b, required credit=20 busy=0", o_credit, o_busy);
    end
    do_txn(1, 0, 1, 1, 4'b0000, 0, 0);
    do_txn(1, 0, 0, 0, 4'b0000, 1, 0);
    do_txn(1, 0, 1, 1, 4'b0000, 0, 0);
    checks++;
    if (o_credit !== 6'd25 || o_rej !== 1'b1) begin
      failures++;
      $display("FAIL multi_coin: credit=%0d rej=%b, required credit=25 rej=1", o_credit, o_rej);
    end
  endtask

  task automatic test_random(int u, int count);
    int r, np;
    logic [2:0] cb;
    logic [3:0] s;
    bit c, rs;
    np = m_np[u];
    for (int t = 0; t < count; t++) begin
      r = $urandom_range(0, 99);
      cb = 3'b000; s = 4'b0000; c = 0; rs = 0;
      if (r < 55) begin
        cb = 3'($urandom_range(1, 7));
      end else if (r < 80) begin
        if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(1, (1 << np) - 1));
        else s = 4'(1 << $urandom_range(0, np - 1));
      end else if (r < 88) begin
        c = 1;
        if ($urandom_range(0, 3) == 0) cb = 3'($urandom_range(1, 7));
      end else if (r < 93) begin
        rs = 1;
      end else begin
        s = 4'(1 << $urandom_range(0, np - 1));
        cb = 3'($urandom_range(1, 7));
      end
      do_txn(u, cb[0], cb[1], cb[2], s, c, rs);
    end
  endtask

  initial begin
    idle_inputs(0);
    idle_inputs(1);
    reset0 = 1'b1;
    reset1 = 1'b1;
    test_reset(0);
    test_reset(1);
    test_basic;
    test_overflow;
    test_deny;
    test_sold_out;
    test_busy_inject;
    test_reset_mid_change;
    test_random(0, 150);
    test_no_auto;
    test_random(1, 100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
